// File: rtl/ras_shadow_stack_mc.sv
// ras_shadow_stack_mc
//   Multi-context return-address shadow stack with hardware return checking.
//   A call pushes its return address onto the stack of the selected context.
//   A return pops that stack and compares the popped value with the actual
//   return target. The pass/violation result is registered and appears one
//   cycle later. One instance serves NUM_CTX harts or privilege contexts.
//
// Optional feature: define RAS_SS_LOCK_EN to add a per-context lock FSM
//   (NORMAL -> LOCKED on a violation). A locked context ignores push and pop.
//   Only i_flush on that context, or rst, unlocks it.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   i_ctx        context used for this cycle's operation and status outputs
//   i_push       call: push i_push_data
//   i_pop        return: pop and check against i_pop_addr
//   i_flush      empty the selected context, clear its lost counter and lock
//   o_chk_*      registered check result (valid/ok)
//   o_violation  registered one-cycle violation pulse, context in o_viol_ctx
//   o_top, o_count, o_full, o_empty, o_overflow, o_locked
//                combinational status of the selected context
module ras_shadow_stack_mc #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned NUM_CTX  = 2,
   parameter int unsigned OVF_MODE = 0,
   parameter int unsigned LOST_W   = 8,
   localparam int unsigned CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTX_W-1:0]  i_ctx,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_pop_addr,
   input  logic              i_flush,
   output logic              o_chk_valid,
   output logic              o_chk_ok,
   output logic              o_violation,
   output logic [CTX_W-1:0]  o_viol_ctx,
   output logic [DATA_W-1:0] o_top,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overflow,
   output logic              o_locked
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem  [NUM_CTX][DEPTH];
   logic [PTR_W-1:0]  wptr [NUM_CTX];
   logic [CNT_W-1:0]  cnt  [NUM_CTX];
   logic [LOST_W-1:0] lost [NUM_CTX];
   logic [NUM_CTX-1:0] locked_vec;

   logic              ctx_valid;
   logic [CTX_W-1:0]  sel;
   logic [PTR_W-1:0]  sel_wptr, top_idx, wptr_inc;
   logic [CNT_W-1:0]  sel_cnt;
   logic [LOST_W-1:0] sel_lost;
   logic              sel_locked;
   logic [DATA_W-1:0] sel_top;
   logic              is_empty, is_full;

   logic              act, do_flush, do_push, do_pop;
   logic [PTR_W-1:0]  nxt_wptr, wr_idx;
   logic [CNT_W-1:0]  nxt_cnt;
   logic [LOST_W-1:0] nxt_lost;
   logic              wr_en;
   logic              chk_valid_d, chk_ok_d, viol_d;

   // Out-of-range contexts read from context 0 but every effect is gated.
   assign ctx_valid  = (32'(i_ctx) < NUM_CTX);
   assign sel        = ctx_valid ? i_ctx : '0;
   assign sel_wptr   = wptr[sel];
   assign sel_cnt    = cnt[sel];
   assign sel_lost   = lost[sel];
   assign sel_locked = locked_vec[sel];
   assign top_idx    = (sel_wptr == '0) ? LAST_P : sel_wptr - 1'b1;
   assign wptr_inc   = (sel_wptr == LAST_P) ? '0 : sel_wptr + 1'b1;
   assign sel_top    = mem[sel][top_idx];
   assign is_empty   = (sel_cnt == '0);
   assign is_full    = (sel_cnt == DEPTH_C);

   always_comb begin
      do_flush    = ctx_valid & i_flush;
      act         = ctx_valid & ~i_flush & ~sel_locked;
      do_push     = act & i_push;
      do_pop      = act & i_pop;
      nxt_wptr    = sel_wptr;
      nxt_cnt     = sel_cnt;
      nxt_lost    = sel_lost;
      wr_en       = 1'b0;
      wr_idx      = sel_wptr;
      chk_valid_d = 1'b0;
      chk_ok_d    = 1'b0;
      viol_d      = 1'b0;
      if (do_flush) begin
         nxt_wptr = '0;
         nxt_cnt  = '0;
         nxt_lost = '0;
      end else if (do_pop) begin
         chk_valid_d = 1'b1;
         if (!is_empty) begin
            chk_ok_d = (sel_top == i_pop_addr);
            if (do_push) begin
               // Tail call: the checked top is replaced in place.
               wr_en  = 1'b1;
               wr_idx = top_idx;
            end else begin
               nxt_wptr = top_idx;
               nxt_cnt  = sel_cnt - 1'b1;
            end
         end else begin
            // Empty pop: a return whose entry was lost is unverifiable, not bad.
            if (sel_lost != '0) begin
               chk_ok_d = 1'b1;
               nxt_lost = sel_lost - 1'b1;
            end
            if (do_push) begin
               wr_en    = 1'b1;
               nxt_wptr = wptr_inc;
               nxt_cnt  = CNT_W'(1);
            end
         end
         viol_d = ~chk_ok_d;
      end else if (do_push) begin
         if (!is_full) begin
            wr_en    = 1'b1;
            nxt_wptr = wptr_inc;
            nxt_cnt  = sel_cnt + 1'b1;
         end else begin
            if (sel_lost != '1) begin
               nxt_lost = sel_lost + 1'b1;
            end
            // Ring mode: when full, wptr addresses the oldest entry.
            if (OVF_MODE == 1) begin
               wr_en    = 1'b1;
               nxt_wptr = wptr_inc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CTX; c++) begin
            wptr[c] <= '0;
            cnt[c]  <= '0;
            lost[c] <= '0;
            for (int unsigned d = 0; d < DEPTH; d++) begin
               mem[c][d] <= '0;
            end
         end
         o_chk_valid <= 1'b0;
         o_chk_ok    <= 1'b0;
         o_violation <= 1'b0;
         o_viol_ctx  <= '0;
      end else begin
         if (ctx_valid) begin
            wptr[sel] <= nxt_wptr;
            cnt[sel]  <= nxt_cnt;
            lost[sel] <= nxt_lost;
         end
         if (wr_en) begin
            mem[sel][wr_idx] <= i_push_data;
         end
         o_chk_valid <= chk_valid_d;
         o_chk_ok    <= chk_ok_d;
         o_violation <= viol_d;
         o_viol_ctx  <= viol_d ? i_ctx : '0;
      end
   end

`ifdef RAS_SS_LOCK_EN
   typedef enum logic {LK_NORMAL, LK_LOCKED} lock_state_e;
   lock_state_e lk_state [NUM_CTX];
   lock_state_e lk_next  [NUM_CTX];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CTX; c++) begin
            lk_state[c] <= LK_NORMAL;
         end
      end else begin
         lk_state <= lk_next;
      end
   end

   always_comb begin
      lk_next = lk_state;
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
         if (ctx_valid && (sel == CTX_W'(c))) begin
            if (i_flush) begin
               lk_next[c] = LK_NORMAL;
            end else if (viol_d) begin
               lk_next[c] = LK_LOCKED;
            end
         end
      end
   end

   always_comb begin
      locked_vec = '0;
      for (int unsigned c = 0; c < NUM_CTX; c++) begin
         locked_vec[c] = (lk_state[c] == LK_LOCKED);
      end
   end
`else
   assign locked_vec = '0;
`endif

   assign o_top      = (ctx_valid && !is_empty) ? sel_top : '0;
   assign o_count    = ctx_valid ? sel_cnt : '0;
   assign o_full     = ctx_valid & is_full;
   assign o_empty    = ctx_valid & is_empty;
   assign o_overflow = ctx_valid & (sel_lost != '0);
   assign o_locked   = ctx_valid & sel_locked;

endmodule

// File: tb/tb_ras_shadow_stack_mc.sv
// Testbench for ras_shadow_stack_mc. It uses two instances, one saturating
// (OVF_MODE=0) and one circular (OVF_MODE=1). Both receive the same inputs,
// except that each has its own pop address. Expected check results go into a
// queue when stimulus is driven and are popped one cycle later.
module tb_ras_shadow_stack_mc;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned NCTX   = 2;
`ifdef RAS_SS_LOCK_EN
   localparam bit LK = 1'b1;
`else
   localparam bit LK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [0:0]        i_ctx;
   logic              i_push, i_pop, i_flush;
   logic [DATA_W-1:0] i_push_data, i_pop_addr, r_pop_addr;

   logic              o_chk_valid, o_chk_ok, o_violation, o_full, o_empty, o_overflow, o_locked;
   logic [0:0]        o_viol_ctx;
   logic [DATA_W-1:0] o_top;
   logic [3:0]        o_count;
   logic              r_chk_valid, r_chk_ok, r_violation, r_full, r_empty, r_overflow, r_locked;
   logic [0:0]        r_viol_ctx;
   logic [DATA_W-1:0] r_top;
   logic [3:0]        r_count;

   always #5 clk = ~clk;

   ras_shadow_stack_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CTX(NCTX), .OVF_MODE(0), .LOST_W(8)) dut (
      .clk(clk), .rst(rst), .i_ctx(i_ctx), .i_push(i_push), .i_push_data(i_push_data),
      .i_pop(i_pop), .i_pop_addr(i_pop_addr), .i_flush(i_flush),
      .o_chk_valid(o_chk_valid), .o_chk_ok(o_chk_ok), .o_violation(o_violation),
      .o_viol_ctx(o_viol_ctx), .o_top(o_top), .o_count(o_count), .o_full(o_full),
      .o_empty(o_empty), .o_overflow(o_overflow), .o_locked(o_locked));

   ras_shadow_stack_mc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CTX(NCTX), .OVF_MODE(1), .LOST_W(8)) dut_r (
      .clk(clk), .rst(rst), .i_ctx(i_ctx), .i_push(i_push), .i_push_data(i_push_data),
      .i_pop(i_pop), .i_pop_addr(r_pop_addr), .i_flush(i_flush),
      .o_chk_valid(r_chk_valid), .o_chk_ok(r_chk_ok), .o_violation(r_violation),
      .o_viol_ctx(r_viol_ctx), .o_top(r_top), .o_count(r_count), .o_full(r_full),
      .o_empty(r_empty), .o_overflow(r_overflow), .o_locked(r_locked));

   typedef struct {
      bit         chk_r;
      bit         v, ok, viol;
      logic [0:0] vctx;
   } exp_t;

   typedef struct {
      logic [0:0]  ctx;
      bit          push;
      logic [31:0] pd;
      bit          pop;
      logic [31:0] pa;
      bit          fl;
      bit          v, ok, viol;
      logic [3:0]  cnt;
      logic [31:0] top;
      bit          lk;
   } vec_t;

   exp_t q[$];
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      i_push = 1'b0; i_pop = 1'b0; i_flush = 1'b0;
      i_push_data = '0; i_pop_addr = '0; r_pop_addr = '0;
   endtask

   // One clock; the registered result is compared with the queued expectation.
   task automatic tick(input string tag, input exp_t e);
      exp_t x;
      q.push_back(e);
      @(posedge clk);
      #1;
      x = q.pop_front();
      chk({tag, " chk_valid"}, 64'(o_chk_valid), 64'(x.v));
      chk({tag, " chk_ok"}, 64'(o_chk_ok), 64'(x.ok));
      chk({tag, " violation"}, 64'(o_violation), 64'(x.viol));
      chk({tag, " viol_ctx"}, 64'(o_viol_ctx), 64'(x.vctx));
      if (x.chk_r) begin
         chk({tag, " r chk_valid"}, 64'(r_chk_valid), 64'(x.v));
         chk({tag, " r chk_ok"}, 64'(r_chk_ok), 64'(x.ok));
         chk({tag, " r violation"}, 64'(r_violation), 64'(x.viol));
      end
   endtask

   task automatic stat(input string tag, input int cnt, input logic [31:0] top, input bit ovf, input bit lk);
      chk({tag, " count"}, 64'(o_count), 64'(cnt));
      chk({tag, " top"}, 64'(o_top), 64'(top));
      chk({tag, " full"}, 64'(o_full), 64'(cnt == DEPTH));
      chk({tag, " empty"}, 64'(o_empty), 64'(cnt == 0));
      chk({tag, " overflow"}, 64'(o_overflow), 64'(ovf));
      chk({tag, " locked"}, 64'(o_locked), 64'(lk));
   endtask

   task automatic rstat(input string tag, input int cnt, input logic [31:0] top, input bit ovf);
      chk({tag, " r count"}, 64'(r_count), 64'(cnt));
      chk({tag, " r top"}, 64'(r_top), 64'(top));
      chk({tag, " r full"}, 64'(r_full), 64'(cnt == DEPTH));
      chk({tag, " r overflow"}, 64'(r_overflow), 64'(ovf));
   endtask

   task automatic add(input logic [0:0] ctx, input bit push, input logic [31:0] pd,
                      input bit pop, input logic [31:0] pa, input bit fl,
                      input bit v, input bit ok, input bit viol,
                      input logic [3:0] cnt, input logic [31:0] top, input bit lk);
      vec_t t;
      t.ctx = ctx; t.push = push; t.pd = pd; t.pop = pop; t.pa = pa; t.fl = fl;
      t.v = v; t.ok = ok; t.viol = viol; t.cnt = cnt; t.top = top; t.lk = lk;
      tbl.push_back(t);
   endtask

   function automatic exp_t mk(input bit chk_r, input bit v, input bit ok, input bit viol, input logic [0:0] vctx);
      exp_t e;
      e.chk_r = chk_r; e.v = v; e.ok = ok; e.viol = viol; e.vctx = vctx;
      return e;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick("reset", mk(1'b1, 0, 0, 0, 1'b0));
      tick("reset2", mk(1'b1, 0, 0, 0, 1'b0));
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      i_ctx = '0;
      idle();

      // ctx, push, pd, pop, pa, flush, valid, ok, viol, count, top, locked
      add(0, 1, 32'h100, 0, 0,       0, 0, 0, 0, 1, 32'h100, 0);
      add(0, 1, 32'h200, 0, 0,       0, 0, 0, 0, 2, 32'h200, 0);
      add(0, 1, 32'h300, 0, 0,       0, 0, 0, 0, 3, 32'h300, 0);
      add(0, 0, 0,       1, 32'h300, 0, 1, 1, 0, 2, 32'h200, 0);
      add(0, 0, 0,       1, 32'h200, 0, 1, 1, 0, 1, 32'h100, 0);
      add(0, 0, 0,       1, 32'h100, 0, 1, 1, 0, 0, 32'h0,   0);
      add(0, 1, 32'hA0,  0, 0,       0, 0, 0, 0, 1, 32'hA0,  0);
      add(0, 0, 0,       1, 32'hB0,  0, 1, 0, 1, 0, 32'h0,   LK);
      add(0, 1, 32'hC0,  0, 0,       0, 0, 0, 0, LK ? 4'd0 : 4'd1, LK ? 32'h0 : 32'hC0, LK);
      add(0, 0, 0,       0, 0,       1, 0, 0, 0, 0, 32'h0,   0);
      add(0, 1, 32'h33,  0, 0,       0, 0, 0, 0, 1, 32'h33,  0);
      add(0, 1, 32'h44,  0, 0,       0, 0, 0, 0, 2, 32'h44,  0);
      add(0, 1, 32'h55,  1, 32'h44,  0, 1, 1, 0, 2, 32'h55,  0);
      add(0, 1, 32'h66,  1, 32'h99,  0, 1, 0, 1, 2, 32'h66,  LK);
      add(0, 0, 0,       0, 0,       1, 0, 0, 0, 0, 32'h0,   0);
      add(0, 1, 32'h77,  1, 32'h12,  0, 1, 0, 1, 1, 32'h77,  LK);
      add(0, 0, 0,       0, 0,       1, 0, 0, 0, 0, 32'h0,   0);
      add(0, 1, 32'h11,  0, 0,       0, 0, 0, 0, 1, 32'h11,  0);
      add(1, 1, 32'h22,  0, 0,       0, 0, 0, 0, 1, 32'h22,  0);
      add(1, 0, 0,       1, 32'h22,  0, 1, 1, 0, 0, 32'h0,   0);
      add(0, 0, 0,       0, 0,       0, 0, 0, 0, 1, 32'h11,  0);
      add(1, 0, 0,       1, 32'h5,   0, 1, 0, 1, 0, 32'h0,   LK);
      add(1, 0, 0,       0, 0,       1, 0, 0, 0, 0, 32'h0,   0);
      add(0, 0, 0,       0, 0,       0, 0, 0, 0, 1, 32'h11,  0);

      do_reset();
      stat("after reset", 0, 32'h0, 0, 0);
      i_ctx = 1'b1; #1;
      stat("after reset c1", 0, 32'h0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         string tag;
         tag = $sformatf("row%0d", i);
         i_ctx = tbl[i].ctx; i_push = tbl[i].push; i_push_data = tbl[i].pd;
         i_pop = tbl[i].pop; i_pop_addr = tbl[i].pa; r_pop_addr = tbl[i].pa; i_flush = tbl[i].fl;
         tick(tag, mk(1'b0, tbl[i].v, tbl[i].ok, tbl[i].viol, tbl[i].viol ? tbl[i].ctx : 1'b0));
         stat(tag, int'(tbl[i].cnt), tbl[i].top, 1'b0, tbl[i].lk);
         idle();
      end

      // Overflow: saturating keeps 1..8; ring keeps 3..10. Both lose 2 entries.
      do_reset();
      i_ctx = 1'b0;
      for (int v = 1; v <= 10; v++) begin
         i_push = 1'b1; i_push_data = 32'(v);
         tick($sformatf("ovf push%0d", v), mk(1'b1, 0, 0, 0, 1'b0));
      end
      idle(); #1;
      stat("ovf full", 8, 32'd8, 1'b1, 1'b0);
      rstat("ovf full", 8, 32'd10, 1'b1);
      for (int k = 0; k < 8; k++) begin
         i_pop = 1'b1; i_pop_addr = 32'(8 - k); r_pop_addr = 32'(10 - k);
         tick($sformatf("ovf pop%0d", k), mk(1'b1, 1, 1, 0, 1'b0));
      end
      idle(); #1;
      stat("ovf drained", 0, 32'h0, 1'b1, 1'b0);
      rstat("ovf drained", 0, 32'h0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         i_pop = 1'b1; i_pop_addr = 32'hDEAD; r_pop_addr = 32'hDEAD;
         tick($sformatf("lost pop%0d", k), mk(1'b1, 1, 1, 0, 1'b0));
      end
      idle(); #1;
      stat("lost drained", 0, 32'h0, 1'b0, 1'b0);
      rstat("lost drained", 0, 32'h0, 1'b0);
      i_pop = 1'b1; i_pop_addr = 32'h1; r_pop_addr = 32'h1;
      tick("underflow", mk(1'b1, 1, 0, 1, 1'b0));
      idle(); #1;
      stat("underflow", 0, 32'h0, 1'b0, LK);

      // A reset during a pop discards the result and clears every context.
      do_reset();
      i_ctx = 1'b0; i_push = 1'b1; i_push_data = 32'h11;
      tick("mid push0", mk(1'b1, 0, 0, 0, 1'b0));
      i_ctx = 1'b1; i_push_data = 32'h22;
      tick("mid push1", mk(1'b1, 0, 0, 0, 1'b0));
      idle();
      i_ctx = 1'b0; i_pop = 1'b1; i_pop_addr = 32'h11; r_pop_addr = 32'h11; rst = 1'b1;
      tick("mid reset", mk(1'b1, 0, 0, 0, 1'b0));
      rst = 1'b0; idle();
      stat("mid c0", 0, 32'h0, 1'b0, 1'b0);
      i_ctx = 1'b1; #1;
      stat("mid c1", 0, 32'h0, 1'b0, 1'b0);
      tick("post reset", mk(1'b1, 0, 0, 0, 1'b0));

      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d left expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
